// File: rtl/mul_digit_serial.sv
// mul_digit_serial: iterative unsigned N x N multiplier that feeds one 2-bit digit pair
// per cycle into a 2x2 leaf multiplier and accumulates shifted partial products.
module mul_2_bits (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    assign p = {2'b00, a} * {2'b00, b};
endmodule

module mul_digit_serial #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] c
);
    localparam int D  = N / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int W2 = 2 * N;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [W2-1:0]   acc_q, acc_d, c_q, c_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;
    logic [1:0]      da, db;
    logic [3:0]      pp;
    logic [IW:0]     sh_sum;
    logic [W2-1:0]   pp_sh;
    logic            last_i, last_j;

    assign da     = 2'(a_q >> {i_q, 1'b0});
    assign db     = 2'(b_q >> {j_q, 1'b0});
    assign sh_sum = {1'b0, i_q} + {1'b0, j_q};
    assign pp_sh  = W2'(pp) << {sh_sum, 1'b0};
    assign last_i = i_q == LAST;
    assign last_j = j_q == LAST;

    mul_2_bits u_leaf (.a(da), .b(db), .p(pp));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                acc_d   = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = acc_q + pp_sh;
                j_d   = last_j ? '0 : j_q + 1'b1;
                i_d   = last_j ? i_q + 1'b1 : i_q;
                // final digit pair: publish the completed sum directly
                if (last_i && last_j) begin
                    c_d     = acc_q + pp_sh;
                    i_d     = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign ready = state_q == IDLE;
    assign done  = state_q == DONE;
    assign c     = c_q;
endmodule

// File: tb/tb_mul_digit_serial.sv
// tb_mul_digit_serial: scoreboard bench driving N=8, N=2 and N=16 multipliers with
// directed and random operands; a cycle model predicts ready/done and the queue holds products.
module tb_mul_digit_serial;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    int K[3] = '{16, 1, 64};
    int W[3] = '{8, 2, 16};

    logic        start_i[3];
    logic [15:0] a_i[3], b_i[3];
    logic        ready_o[3], done_o[3];
    logic [31:0] c_o[3];
    logic [15:0] c8;
    logic [3:0]  c2;
    logic [31:0] c16;

    mul_digit_serial #(.N(8)) u8 (.clk(clk), .rst(rst), .start(start_i[0]), .a(a_i[0][7:0]),
        .b(b_i[0][7:0]), .ready(ready_o[0]), .done(done_o[0]), .c(c8));
    mul_digit_serial #(.N(2)) u2 (.clk(clk), .rst(rst), .start(start_i[1]), .a(a_i[1][1:0]),
        .b(b_i[1][1:0]), .ready(ready_o[1]), .done(done_o[1]), .c(c2));
    mul_digit_serial #(.N(16)) u16 (.clk(clk), .rst(rst), .start(start_i[2]), .a(a_i[2]),
        .b(b_i[2]), .ready(ready_o[2]), .done(done_o[2]), .c(c16));

    assign c_o[0] = {16'b0, c8};
    assign c_o[1] = {28'b0, c2};
    assign c_o[2] = c16;

    int          checks = 0, passes = 0;
    int          cyc = 0;
    int          cnt[3] = '{0, 0, 0};
    int          acc_cyc[3] = '{0, 0, 0};
    int          dn_cyc[3] = '{0, 0, 0};
    int          prev_dn[3] = '{0, 0, 0};
    logic [31:0] c_m[3] = '{0, 0, 0};
    logic [31:0] sb[3][$];
    logic        rst_q = 0;
    logic        mon = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: accept when idle, busy for K RUN cycles plus one DONE cycle
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                cnt[d] <= 0;
                sb[d].delete();
            end else if (cnt[d] == 0 && start_i[d]) begin
                cnt[d]     <= K[d] + 1;
                acc_cyc[d] <= cyc;
                sb[d].push_back(32'(a_i[d]) * 32'(b_i[d]));
            end else if (cnt[d] != 0) begin
                cnt[d] <= cnt[d] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon) begin
            for (int d = 0; d < 3; d++) begin
                if (rst_q) c_m[d] = 0;
                chk("ready", d, 32'(ready_o[d]), 32'(cnt[d] == 0));
                chk("done", d, 32'(done_o[d]), 32'(cnt[d] == 1));
                chk("ready_done_excl", d, 32'(ready_o[d] & done_o[d]), 0);
                if (done_o[d] === 1'b1) begin
                    prev_dn[d] = dn_cyc[d];
                    dn_cyc[d]  = cyc;
                    if (sb[d].size() == 0) chk("sb_underflow", d, 1, 0);
                    else begin
                        c_m[d] = sb[d].pop_front();
                        chk("latency", d, 32'(cyc - acc_cyc[d]), 32'(K[d] + 1));
                    end
                end
                chk("c", d, c_o[d], c_m[d]);
            end
        end
    end

    task automatic go(input int d, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (cnt[d] != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) chk("ready_timeout", d, 0, 1);
        start_i[d] = 1;
        a_i[d]     = 16'(x & ((32'd1 << W[d]) - 1));
        b_i[d]     = 16'(y & ((32'd1 << W[d]) - 1));
        tick();
        start_i[d] = 0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (cnt[d] != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) chk("idle_timeout", d, 0, 1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start_i[d] = 1;
            a_i[d]     = 16'd1;
            b_i[d]     = 16'd1;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", d, 32'(ready_o[d]), 1);
            chk("rst_done", d, 32'(done_o[d]), 0);
            chk("rst_c", d, c_o[d], 0);
            start_i[d] = 0;
        end
        rst = 0;
        mon = 1;
        tick();

        go(0, 255, 255);
        wait_idle(0);
        repeat (3) tick();
        chk("max_hold", 0, c_o[0], 65025);

        go(0, 0, 173);
        go(0, 13, 11);
        wait_idle(0);
        chk("b2b_c", 0, c_o[0], 143);
        chk("b2b_spacing", 0, 32'(dn_cyc[0] - prev_dn[0]), 18);

        go(0, 200, 3);
        start_i[0] = 1;
        a_i[0]     = 16'd1;
        b_i[0]     = 16'd1;
        repeat (16) tick();
        chk("held_start_c", 0, c_o[0], 600);
        repeat (2) tick();
        start_i[0] = 0;
        wait_idle(0);
        chk("held_start_next", 0, c_o[0], 1);
        chk("held_start_spacing", 0, 32'(dn_cyc[0] - prev_dn[0]), 18);

        go(0, 77, 91);
        repeat (7) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_ready", 0, 32'(ready_o[0]), 1);
        chk("abort_c", 0, c_o[0], 0);
        chk("abort_done", 0, 32'(done_o[0]), 0);
        repeat (20) tick();
        chk("abort_no_done", 0, 32'(done_o[0]), 0);
        go(0, 77, 91);
        wait_idle(0);
        chk("after_abort_c", 0, c_o[0], 7007);

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) go(1, x, y);
        wait_idle(1);
        chk("n2_last", 1, c_o[1], 9);

        for (int r = 0; r < 8; r++) begin
            go(0, $urandom, $urandom);
            go(2, $urandom, $urandom);
        end
        go(2, 65535, 65535);
        wait_idle(0);
        wait_idle(2);
        chk("n16_max", 2, c_o[2], 32'hFFFE0001);
        repeat (3) tick();
        for (int d = 0; d < 3; d++) chk("sb_empty", d, sb[d].size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_digit_serial.md
# mul_digit_serial

Sequential unsigned multiplier for N-bit operands that feeds one 2-bit × 2-bit digit pair per cycle into an internal `mul_2_bits` instance. It accumulates the shifted 4-bit partial products into a 2N-bit result. The block is the iterative front end around the 2-bit multiplier leaf, used where area matters more than latency. It takes a start/ready handshake from the operand source and returns the product with a one-cycle done pulse.

## Interface
- `N`, default 8: operand width in bits. Must be even and ≥ 2. Digit count D = N/2; iteration count K = D².
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  synchronous reset, active-high
- `start`  input  1  request to multiply; accepted only when `ready` = 1
- `a`  input  N  left operand, unsigned; sampled on the accepting edge only
- `b`  input  N  right operand, unsigned; sampled on the accepting edge only
- `ready`  output  1  high while idle and able to accept `start`
- `done`  output  1  one-cycle pulse, high when `c` holds a new product
- `c`  output  2N  product a×b, held until the next accepted `start`

## Operation
- States:
  - IDLE: `ready` = 1. `start` = 1 → latch `a`/`b` into internal operand registers, clear the accumulator and digit indices i, j to 0, go to RUN.
  - RUN: each cycle, feed digit a[2i+1:2i] and digit b[2j+1:2j] to `mul_2_bits`.
    - Add its 4-bit output, zero-extended to 2N bits and shifted left by 2(i+j), into the accumulator.
    - j increments every cycle (inner loop). When j = D−1, j wraps to 0 and i increments.
    - On the cycle with i = D−1 and j = D−1: load `c` with accumulator + final partial product, go to DONE.
  - DONE: `done` = 1 for exactly this cycle, `ready` = 0. Unconditionally go to IDLE.
- Arithmetic:
  - Accumulator is 2N bits. The sum never exceeds (2^N−1)², so there is no overflow and no carry-out.
  - All operands are unsigned.
- `start` while `ready` = 0 is ignored: no effect on the operation in flight, and it is not queued.
- Operand inputs may change freely after the accepting edge; only the latched copies are used.
- `c` changes only on the edge entering DONE, and on reset.
- Reset, synchronous, overrides everything including mid-RUN and DONE:
  - state → IDLE; `ready` = 1; `done` = 0; `c` = 0; accumulator, indices and operand registers = 0.
  - An aborted operation never asserts `done`.

## Timing
- Reset values: `ready` = 1, `done` = 0, `c` = 0.
- `start` accepted at rising edge t → RUN occupies cycles t+1 … t+K.
- `done` = 1 and `c` valid during cycle t+K+1. `ready` = 1 again from cycle t+K+2.
- Latency from accepting edge to `done` = K+1 cycles. N=8: K=16, done in cycle t+17.
- Maximum throughput is one product per K+2 cycles. The earliest next `start` is sampled at the edge ending cycle t+K+1 only if `ready` = 1, which it is not, so the next accept is at edge t+K+2.
- N=2: K=1, RUN lasts one cycle, `done` at t+2.
- `ready` and `done` are never high in the same cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `start` = 1 → `ready` = 1, `done` = 0, `c` = 0. No operation starts while `rst` is high.
- N=8, a=255, b=255, `start` pulse at edge t → `done` high only in cycle t+17 with `c` = 65025. `c` is held at 65025 afterwards. `ready` low during t+1 … t+17.
- N=8, a=0, b=173, then a=13, b=11 back-to-back, with `start` asserted at the first cycle `ready` = 1 → first `c` = 0, then `c` = 143. The second start is accepted exactly 18 cycles after the first.
- N=8, a=200, b=3, then `start` held high with a=1, b=1 throughout RUN → single result `c` = 600. A second operation begins only after `ready` returns.
- N=8, a=77, b=91, `rst` pulsed at cycle t+8 → no `done` pulse. `c` = 0, `ready` = 1 the cycle after reset. A fresh `start` with a=77, b=91 then yields `c` = 7007.
- N=2 instance: exhaustive a,b ∈ {0..3} → `done` 2 cycles after each accept, `c` = a×b (e.g. 3×3 → 9). Plus randomized N=8 and N=16 runs checked against a reference product.
